// File: rtl/ysyx_25030093_wb_pkg.sv
// Shared constants for the writeback sequencer: FSM encoding and machine-mode CSR identifiers.
package ysyx_25030093_wb_pkg;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD_WAIT = 3'd1;
  localparam logic [2:0] S_GPR_WB    = 3'd2;
  localparam logic [2:0] S_CSR_WB    = 3'd3;
  localparam logic [2:0] S_EC_EPC    = 3'd4;
  localparam logic [2:0] S_EC_CAUSE  = 3'd5;

  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
endpackage

// File: rtl/ysyx_25030093_wb_timeout.sv
// Load-wait cycle counter: synchronous clear has priority over enable; tc flags LOAD_TIMEOUT-1.
module ysyx_25030093_wb_timeout #(
  parameter int LOAD_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(LOAD_TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == CW'(LOAD_TIMEOUT - 1));
endmodule

// File: rtl/ysyx_25030093_wb_ctrl.sv
// Writeback sequencer: latches one retiring instruction and serialises its GPR/CSR writes.
// Handshake: an instruction transfers on a cycle where in_valid && in_ready; in_ready is high only in IDLE.
module ysyx_25030093_wb_ctrl
  import ysyx_25030093_wb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int LOAD_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [DATA_WIDTH-1:0] in_alu_res,
  input  logic                  in_is_load,
  input  logic                  in_csr_wen,
  input  logic [11:0]           in_csr_addr,
  input  logic [DATA_WIDTH-1:0] in_csr_wdata,
  input  logic                  in_ecall,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic                  lsu_rvalid,
  input  logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  gpr_wen,
  output logic [ADDR_WIDTH-1:0] gpr_waddr,
  output logic [DATA_WIDTH-1:0] gpr_wdata,
  output logic                  csr_wen,
  output logic [11:0]           csr_waddr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  commit_valid,
  output logic                  commit_fault,
  output logic                  load_fault,
  output logic [2:0]            dbg_state
);
  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] gpr_data_q, gpr_data_d;
  logic                  csr_wen_q, csr_wen_d;
  logic [11:0]           csr_addr_q, csr_addr_d;
  logic [DATA_WIDTH-1:0] csr_data_q, csr_data_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  fault_q, fault_d;
  logic                  load_fault_q, load_fault_d;
  logic                  accept, cnt_en, tc;

  assign accept = (state_q == S_IDLE) && in_valid;
  // Counting starts on the accept edge so the fault commit lands LOAD_TIMEOUT cycles after accept.
  assign cnt_en = (accept && !in_ecall && in_is_load) || (state_q == S_LOAD_WAIT);

  ysyx_25030093_wb_timeout #(.LOAD_TIMEOUT(LOAD_TIMEOUT)) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (!cnt_en),
    .en  (cnt_en),
    .tc  (tc)
  );

  always_comb begin
    state_d      = state_q;
    rd_d         = rd_q;
    gpr_data_d   = gpr_data_q;
    csr_wen_d    = csr_wen_q;
    csr_addr_d   = csr_addr_q;
    csr_data_d   = csr_data_q;
    pc_d         = pc_q;
    fault_d      = 1'b0;
    load_fault_d = load_fault_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rd_d       = in_rd;
          gpr_data_d = in_alu_res;
          csr_wen_d  = in_csr_wen;
          csr_addr_d = in_csr_addr;
          csr_data_d = in_csr_wdata;
          pc_d       = in_pc;
          if (in_ecall)        state_d = S_EC_EPC;
          else if (in_is_load) state_d = S_LOAD_WAIT;
          else                 state_d = S_GPR_WB;
        end
      end
      S_LOAD_WAIT: begin
        if (lsu_rvalid) begin
          gpr_data_d = lsu_rdata;
          state_d    = S_GPR_WB;
        end else if (tc) begin
          fault_d      = 1'b1;
          load_fault_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      S_GPR_WB:   state_d = csr_wen_q ? S_CSR_WB : S_IDLE;
      S_CSR_WB:   state_d = S_IDLE;
      S_EC_EPC:   state_d = S_EC_CAUSE;
      S_EC_CAUSE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rd_q         <= '0;
      gpr_data_q   <= '0;
      csr_wen_q    <= 1'b0;
      csr_addr_q   <= '0;
      csr_data_q   <= '0;
      pc_q         <= '0;
      fault_q      <= 1'b0;
      load_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      gpr_data_q   <= gpr_data_d;
      csr_wen_q    <= csr_wen_d;
      csr_addr_q   <= csr_addr_d;
      csr_data_q   <= csr_data_d;
      pc_q         <= pc_d;
      fault_q      <= fault_d;
      load_fault_q <= load_fault_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign gpr_wen   = (state_q == S_GPR_WB) && (rd_q != '0);
  assign gpr_waddr = rd_q;
  assign gpr_wdata = gpr_data_q;
  assign csr_wen   = (state_q == S_CSR_WB) || (state_q == S_EC_EPC) || (state_q == S_EC_CAUSE);

  always_comb begin
    csr_waddr = csr_addr_q;
    csr_wdata = csr_data_q;
    if (state_q == S_EC_EPC) begin
      csr_waddr = CSR_MEPC;
      csr_wdata = pc_q;
    end else if (state_q == S_EC_CAUSE) begin
      csr_waddr = CSR_MCAUSE;
      csr_wdata = DATA_WIDTH'(CAUSE_ECALL_M);
    end
  end

  // A timed-out load commits from IDLE via the registered fault flag.
  assign commit_valid = ((state_q == S_GPR_WB) && !csr_wen_q) || (state_q == S_CSR_WB) ||
                        (state_q == S_EC_CAUSE) || fault_q;
  assign commit_fault = fault_q;
  assign load_fault   = load_fault_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_ysyx_25030093_wb_ctrl.sv
// Directed bench for the writeback sequencer with hand-computed expectations per cycle.
module tb_ysyx_25030093_wb_ctrl;
  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_res;
  logic        in_is_load, in_csr_wen, in_ecall;
  logic [11:0] in_csr_addr;
  logic [31:0] in_csr_wdata, in_pc;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        commit_valid, commit_fault, load_fault;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int commit_cnt = 0;
  logic [31:0] exp_q[$];

  ysyx_25030093_wb_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .LOAD_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_alu_res(in_alu_res), .in_is_load(in_is_load), .in_csr_wen(in_csr_wen),
    .in_csr_addr(in_csr_addr), .in_csr_wdata(in_csr_wdata), .in_ecall(in_ecall), .in_pc(in_pc),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr),
    .gpr_wdata(gpr_wdata), .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .commit_valid(commit_valid), .commit_fault(commit_fault), .load_fault(load_fault),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // commit monitor, sampled away from the active edge
  always @(negedge clk) if (!rst && commit_valid) commit_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; in_rd = 0; in_alu_res = 0; in_is_load = 0; in_csr_wen = 0;
    in_csr_addr = 0; in_csr_wdata = 0; in_ecall = 0; in_pc = 0;
    lsu_rvalid = 0; lsu_rdata = 0;
  endtask

  // Presents one instruction during cycle T; returns in cycle T+1.
  task automatic send(input logic [4:0] rd, input logic [31:0] alu, input logic ld,
                      input logic cwen, input logic [11:0] caddr, input logic [31:0] cdata,
                      input logic ec, input logic [31:0] pc);
    in_valid = 1; in_rd = rd; in_alu_res = alu; in_is_load = ld; in_csr_wen = cwen;
    in_csr_addr = caddr; in_csr_wdata = cdata; in_ecall = ec; in_pc = pc;
    step();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    step(); step();
    check("rst_ready", in_ready, 1);
    check("rst_gpr_wen", gpr_wen, 0);
    check("rst_csr_wen", csr_wen, 0);
    check("rst_commit", commit_valid, 0);
    check("rst_fault", {commit_fault, load_fault}, 0);
    check("rst_state", dbg_state, 0);
    rst = 0;
    step();

    // ALU op
    send(5'd5, 32'h1234, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(32'h1234);
    check("alu_gpr_wen", gpr_wen, 1);
    check("alu_waddr", gpr_waddr, 5);
    check("alu_wdata", gpr_wdata, exp_q.pop_front());
    check("alu_commit", commit_valid, 1);
    check("alu_busy", in_ready, 0);
    step();
    check("alu_ready_t2", in_ready, 1);
    check("alu_commit_t2", commit_valid, 0);

    // csrrw
    send(5'd3, 32'hAA, 0, 1, 12'h300, 32'h55, 0, 0);
    check("csr_t1_gpr", {gpr_wen, 27'd0, gpr_waddr}, {1'b1, 27'd0, 5'd3});
    check("csr_t1_wdata", gpr_wdata, 32'hAA);
    check("csr_t1_nocsr", {csr_wen, commit_valid}, 0);
    step();
    check("csr_t2_wen", {csr_wen, gpr_wen, commit_valid}, 3'b101);
    check("csr_t2_addr", csr_waddr, 12'h300);
    check("csr_t2_data", csr_wdata, 32'h55);
    step();
    check("csr_t3_idle", {in_ready, commit_valid, csr_wen}, 3'b100);

    // ecall with rd, is_load and csr_wen set: those must be ignored
    send(5'd9, 32'h77, 1, 1, 12'h305, 32'h99, 1, 32'h80000010);
    check("ec_t1_wen", {csr_wen, gpr_wen, commit_valid}, 3'b100);
    check("ec_t1_addr", csr_waddr, 12'h341);
    check("ec_t1_data", csr_wdata, 32'h80000010);
    step();
    check("ec_t2_wen", {csr_wen, gpr_wen, commit_valid}, 3'b101);
    check("ec_t2_addr", csr_waddr, 12'h342);
    check("ec_t2_data", csr_wdata, 32'd11);
    step();
    check("ec_t3_idle", {in_ready, gpr_wen, csr_wen}, 3'b100);

    // load: rvalid during accept is ignored, rvalid at T+4 delivers data
    lsu_rvalid = 1; lsu_rdata = 32'h0BAD0BAD;
    send(5'd7, 32'h1111, 1, 0, 0, 0, 0, 0);
    check("ld_t1_wait", dbg_state, 1);
    check("ld_t1_nowrite", {gpr_wen, commit_valid}, 0);
    step();
    in_valid = 1; in_rd = 5'd2; in_alu_res = 32'h2222;
    check("ld_t2_busy", in_ready, 0);
    step();
    in_valid = 0;
    check("ld_t3_wait", {dbg_state, gpr_wen, commit_valid}, 5'b00100);
    step();
    lsu_rvalid = 1; lsu_rdata = 32'hDEADBEEF;
    step();
    clear_inputs();
    check("ld_t5_gpr", {gpr_wen, commit_valid, commit_fault}, 3'b110);
    check("ld_t5_waddr", gpr_waddr, 7);
    check("ld_t5_wdata", gpr_wdata, 32'hDEADBEEF);
    step();
    check("ld_t6_idle", {in_ready, commit_valid}, 2'b10);

    // load timeout with LOAD_TIMEOUT=8: fault commit at T+8
    send(5'd4, 32'h4444, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k < 8; k++) begin
      check($sformatf("to_t%0d_quiet", k), {commit_valid, gpr_wen, csr_wen}, 0);
      step();
    end
    check("to_t8_commit", {commit_valid, commit_fault, load_fault}, 3'b111);
    check("to_t8_nowrite", {gpr_wen, csr_wen}, 0);
    check("to_t8_ready", in_ready, 1);
    step();
    check("to_t9_sticky", {commit_valid, commit_fault, load_fault}, 3'b001);

    // rd=0 ALU op
    send(5'd0, 32'hCAFE, 0, 0, 0, 0, 0, 0);
    check("rd0_gpr_wen", gpr_wen, 0);
    check("rd0_commit", commit_valid, 1);
    step();

    // reset in the middle of a csrrw
    send(5'd3, 32'hAB, 0, 1, 12'h300, 32'h66, 0, 0);
    rst = 1;
    #1;
    check("rstmid_ready", in_ready, 1);
    check("rstmid_gpr", gpr_wen, 0);
    step();
    rst = 0;
    check("rstmid_t2", {csr_wen, commit_valid, in_ready}, 3'b001);
    check("rstmid_lfault", load_fault, 0);
    step();
    check("rstmid_t3", {csr_wen, commit_valid}, 0);

    check("commit_count", commit_cnt, 6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
